num_sink: RTL and testbench

- AXI-Stream receiver endpoint for the NoC; the consuming end of traffic produced by the number generator.
- Accepts packets addressed to this node, checks destination and zero-padding, and buffers the 8-bit payload of each beat in a small FIFO drained through a valid/ready output port.
- Maintains saturating packet, beat, error and checksum statistics for the bench and for debug readout.

---
 rtl/num_sink_if.sv | 28 ++
 rtl/num_sink.sv | 133 +++++++++++++
 tb/tb_num_sink.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/num_sink_if.sv
`default_nettype none
// num_sink_if: AXI-Stream slave channel and payload output channel of num_sink.
interface num_sink_if #(
  parameter int TDATAW = 32,
  parameter int TDESTW = 4,
  parameter int TIDW   = 2
);
  logic              axis_s_tvalid;
  logic              axis_s_tready;
  logic [TDATAW-1:0] axis_s_tdata;
  logic              axis_s_tlast;
  logic [TIDW-1:0]   axis_s_tid;
  logic [TDESTW-1:0] axis_s_tdest;
  logic              o_valid;
  logic              o_ready;
  logic [7:0]        o_data;

  modport slave (
    input  axis_s_tvalid, axis_s_tdata, axis_s_tlast, axis_s_tid, axis_s_tdest, o_ready,
    output axis_s_tready, o_valid, o_data
  );

  modport master (
    output axis_s_tvalid, axis_s_tdata, axis_s_tlast, axis_s_tid, axis_s_tdest, o_ready,
    input  axis_s_tready, o_valid, o_data
  );
endinterface
`default_nettype wire

// File: rtl/num_sink.sv
`default_nettype none
// num_sink: NoC AXI-Stream receive endpoint with payload FIFO and saturating statistics.
// Optional pad check enabled by defining NUM_SINK_PAD_CHECK_EN.
module num_sink #(
  parameter int TDATAW     = 32,
  parameter int TDESTW     = 4,
  parameter int TIDW       = 2,
  parameter int NODE_ID    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CNTW       = 16
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            en,
  input  wire logic            clear,
  num_sink_if.slave            s,
  output logic [CNTW-1:0]      pkt_cnt,
  output logic [CNTW-1:0]      beat_cnt,
  output logic [CNTW-1:0]      dest_err_cnt,
  output logic [CNTW-1:0]      pad_err_cnt,
  output logic [7:0]           checksum
);
  localparam int                AW   = $clog2(FIFO_DEPTH);
  localparam logic [TDESTW-1:0] NODE = TDESTW'(NODE_ID);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        hs;
  logic        store;
  logic        dest_miss;
  logic        pop;
  logic [7:0]  payload;
  logic        unused_inputs;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign payload = s.axis_s_tdata[7:0];

  assign s.axis_s_tready = en & ~rst & ((state == DROP) | ~full);
  assign hs              = s.axis_s_tvalid & s.axis_s_tready;
  assign s.o_valid       = ~empty;
  assign s.o_data        = empty ? 8'd0 : mem[rd_ptr[AW-1:0]];
  assign pop             = s.o_valid & s.o_ready;
  assign unused_inputs   = ^{s.axis_s_tid, s.axis_s_tdata[TDATAW-1:8]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // The first beat alone decides whether a packet is kept or dropped.
  always_comb begin
    state_nx  = state;
    store     = 1'b0;
    dest_miss = 1'b0;
    if (hs) begin
      case (state)
        IDLE: begin
          if (s.axis_s_tdest == NODE) begin
            store = 1'b1;
            if (!s.axis_s_tlast) state_nx = BODY;
          end else begin
            dest_miss = 1'b1;
            if (!s.axis_s_tlast) state_nx = DROP;
          end
        end
        BODY: begin
          store = 1'b1;
          if (s.axis_s_tlast) state_nx = IDLE;
        end
        DROP: begin
          if (s.axis_s_tlast) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr[AW-1:0]] <= payload;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pkt_cnt      <= '0;
      beat_cnt     <= '0;
      dest_err_cnt <= '0;
      checksum     <= '0;
    end else begin
      pkt_cnt      <= sat_inc(pkt_cnt, store & s.axis_s_tlast);
      beat_cnt     <= sat_inc(beat_cnt, store);
      dest_err_cnt <= sat_inc(dest_err_cnt, dest_miss);
      checksum     <= checksum + (store ? payload : 8'd0);
    end
  end

`ifdef NUM_SINK_PAD_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst || clear) pad_err_cnt <= '0;
    else pad_err_cnt <= sat_inc(pad_err_cnt, store & (|s.axis_s_tdata[TDATAW-1:8]));
  end
`else
  assign pad_err_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_num_sink.sv
`default_nettype none
// tb_num_sink: randomized and directed checks of num_sink against a queue-based packet model.
module tb_num_sink;
  localparam int TDATAW     = 32;
  localparam int TDESTW     = 4;
  localparam int TIDW       = 2;
  localparam int NODE_ID    = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int CNTW       = 4;
  localparam int CMAX       = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            clear;
  logic [CNTW-1:0] pkt_cnt, beat_cnt, dest_err_cnt, pad_err_cnt;
  logic [7:0]      checksum;

  num_sink_if #(.TDATAW(TDATAW), .TDESTW(TDESTW), .TIDW(TIDW)) bus ();

  num_sink #(
    .TDATAW(TDATAW), .TDESTW(TDESTW), .TIDW(TIDW), .NODE_ID(NODE_ID),
    .FIFO_DEPTH(FIFO_DEPTH), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .s(bus),
    .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt), .dest_err_cnt(dest_err_cnt),
    .pad_err_cnt(pad_err_cnt), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Packet-level reference: which kind of packet we are inside, and what the FIFO holds.
  logic [7:0] m_q[$];
  bit         in_kept, in_dropped;
  int         m_pkt, m_beat, m_dest, m_pad, m_sum;

`ifdef NUM_SINK_PAD_CHECK_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v + 1 > CMAX) ? CMAX : v + 1;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_ovalid"}, 32'(bus.o_valid), 32'(m_q.size() > 0));
    check({tag, "_odata"},  32'(bus.o_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    check({tag, "_pkt"},    32'(pkt_cnt), 32'(m_pkt));
    check({tag, "_beat"},   32'(beat_cnt), 32'(m_beat));
    check({tag, "_dest"},   32'(dest_err_cnt), 32'(m_dest));
    check({tag, "_pad"},    32'(pad_err_cnt), 32'(m_pad));
    check({tag, "_sum"},    32'(checksum), 32'(m_sum & 255));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.axis_s_tvalid = 1'b0;
    clear = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_q.delete();
    in_kept = 0; in_dropped = 0;
    m_pkt = 0; m_beat = 0; m_dest = 0; m_pad = 0; m_sum = 0;
    check("rst_tready", 32'(bus.axis_s_tready), 32'd0);
    check_outputs("rst");
    rst = 1'b0;
  endtask

  // One clock: drive at the falling edge, check ready, advance the model, check after the edge.
  task automatic step(input bit e, input bit v, input logic [31:0] d, input bit l,
                      input logic [3:0] dst, input bit ordy, input bit clr, output bit acc);
    bit exp_rdy, stored, do_pop;
    en = e; clear = clr;
    bus.axis_s_tvalid = v; bus.axis_s_tdata = d; bus.axis_s_tlast = l;
    bus.axis_s_tdest = dst; bus.axis_s_tid = 2'($urandom); bus.o_ready = ordy;
    #1;
    exp_rdy = e && (in_dropped || m_q.size() < FIFO_DEPTH);
    check("tready", 32'(bus.axis_s_tready), 32'(exp_rdy));
    acc = v && exp_rdy;
    stored = 0;
    do_pop = (m_q.size() > 0) && ordy;
    if (acc) begin
      if (in_dropped) begin
        if (l) in_dropped = 0;
      end else if (in_kept || dst == 4'(NODE_ID)) begin
        stored = 1;
        in_kept = !l;
      end else begin
        if (!clr) m_dest = sat(m_dest);
        in_dropped = !l;
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (stored) m_q.push_back(d[7:0]);
    if (clr) begin
      m_pkt = 0; m_beat = 0; m_dest = 0; m_pad = 0; m_sum = 0;
    end else if (stored) begin
      m_beat = sat(m_beat);
      if (l) m_pkt = sat(m_pkt);
      if (PAD_ON && d[31:8] != 0) m_pad = sat(m_pad);
      m_sum = (m_sum + d[7:0]) & 255;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) step(1, 0, 32'd0, 0, 4'd0, ordy, 0, a);
  endtask

  initial begin
    bit a;
    logic [7:0] bytes3 [3];
    rst = 1'b1; en = 1'b0; clear = 1'b0;
    bus.axis_s_tvalid = 1'b0; bus.axis_s_tdata = '0; bus.axis_s_tlast = 1'b0;
    bus.axis_s_tid = '0; bus.axis_s_tdest = '0; bus.o_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Three single-beat packets, consumer always ready.
    bytes3[0] = 8'h05; bytes3[1] = 8'h0A; bytes3[2] = 8'h10;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, {24'd0, bytes3[i]}, 1, 4'd1, 1, 0, a);
      check("tp1_head", 32'(bus.o_data), 32'(bytes3[i]));
    end
    check("tp1_pkt", 32'(pkt_cnt), 32'd3);
    check("tp1_sum", 32'(checksum), 32'h1F);
    idle(2, 1);

    // Wrong-destination packet dropped, then one accepted beat.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 32'h20 + 32'(i), (i == 2), 4'd2, 1, 0, a);
    step(1, 1, 32'h33, 1, 4'd1, 1, 0, a);
    check("tp2_head", 32'(bus.o_data), 32'h33);
    check("tp2_dest", 32'(dest_err_cnt), 32'd1);
    check("tp2_pkt", 32'(pkt_cnt), 32'd1);
    idle(2, 1);

    // Fill the FIFO with the consumer stalled, then drain.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, 32'h41 + 32'(i), 1, 4'd1, 0, 0, a);
    check("tp3_fifth_stalled", 32'(a), 32'd0);
    a = 0;
    for (int k = 0; k < 10 && !a; k++) step(1, 1, 32'h45, 1, 4'd1, 1, 0, a);
    check("tp3_fifth_accepted", 32'(a), 32'd1);
    idle(6, 1);

    // Nonzero pad bits.
    do_reset();
    step(1, 1, 32'h0000_0107, 1, 4'd1, 0, 0, a);
    check("tp4_head", 32'(bus.o_data), 32'h07);
    check("tp4_pad", 32'(pad_err_cnt), PAD_ON ? 32'd1 : 32'd0);

    // Clear on the same cycle as a stored beat.
    step(1, 1, 32'h0000_0009, 1, 4'd1, 0, 1, a);
    check("tp5_beat", 32'(beat_cnt), 32'd0);
    check("tp5_ovalid", 32'(bus.o_valid), 32'd1);
    idle(3, 1);

    // Reset in the body of a packet; the remaining beats form a new packet.
    do_reset();
    step(1, 1, 32'h61, 0, 4'd1, 0, 0, a);
    do_reset();
    step(1, 1, 32'h62, 0, 4'd1, 0, 0, a);
    step(1, 1, 32'h63, 1, 4'd7, 0, 0, a);
    check("tp6_pkt", 32'(pkt_cnt), 32'd1);
    check("tp6_head", 32'(bus.o_data), 32'h62);
    idle(3, 1);

    // Random traffic, long enough to saturate the narrow counters.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : {24'd0, 8'($urandom)};
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), d,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0) ? 4'd2 : 4'd1,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 60) == 0), a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
